// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stall-bus encodings and the redirect helper for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_ENTRY_DEF = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE_DEF = 32'h0000000E;

  localparam int  STALL_W = 6;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // One bit per pipeline register: 0 PC, 1 IF, 2 IC/ID, 3 ID/EX, 4 EX/MEM, 5 MEM/WB
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  function automatic logic [31:0] redirect_pc(
    input logic [31:0] etype,
    input logic [31:0] epc,
    input logic [31:0] entry,
    input logic [31:0] eret_code
  );
    return (etype == eret_code) ? epc : entry;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_merge.sv
// Priority encoder from per-stage stall requests to the stall bus; the deepest requester wins.
module pipe_ctrl_stall_merge
  import pipe_ctrl_pkg::*;
(
  input  logic       stallreq_from_if,
  input  logic       stallreq_from_id,
  input  logic       stallreq_from_ex,
  input  logic       stallreq_from_mem,
  output stall_bus_t stall_req
);

  always_comb begin
    stall_req = STALL_NONE;
    if (stallreq_from_mem)     stall_req = STALL_MEM;
    else if (stallreq_from_ex) stall_req = STALL_EX;
    else if (stallreq_from_id) stall_req = STALL_ID;
    else if (stallreq_from_if) stall_req = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception/ERET flush with PC redirect, and deferred branch kill.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; exceptions flush at once unless MEM is stalled
// EXC_WAIT | exception captured during a MEM stall, flush when MEM frees
// DRAIN    | flush issued with a fetch outstanding; hold PC/IF, drop word
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter logic [31:0] ERET_CODE = ERET_CODE_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic             br_e,
  input  logic             except_valid,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             br_kill,
  output logic             drop_if,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_WAIT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  state_e           state;
  logic [31:0]      pend_type;
  logic [31:0]      pend_epc;
  logic             br_pend;
  logic             flush_q;
  logic [CNT_W-1:0] cnt;

  stall_bus_t  stall_req;
  stall_bus_t  stall_c;
  logic        exc_take;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        br_kill_c;
  logic        drop_if_c;

  pipe_ctrl_stall_merge u_stall_merge (
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .stall_req         (stall_req)
  );

  always_comb begin
    // The cycle right after a flush sees only the flushed instruction in MEM, so it is ignored.
    exc_take = (state == RUN) && except_valid && !flush_q;
    flush_c  = 1'b0;
    new_pc_c = 32'h0;
    if (exc_take && !stallreq_from_mem) begin
      flush_c  = 1'b1;
      new_pc_c = redirect_pc(excepttype_i, cp0_epc_i, EXC_ENTRY, ERET_CODE);
    end else if (state == EXC_WAIT && !stallreq_from_mem) begin
      flush_c  = 1'b1;
      new_pc_c = redirect_pc(pend_type, pend_epc, EXC_ENTRY, ERET_CODE);
    end

    stall_c = stall_req;
    if (state == DRAIN) stall_c[1:0] = {STOP, STOP};
    if (flush_c)        stall_c      = STALL_NONE;

    drop_if_c = (state == DRAIN) && !stallreq_from_if;

    br_kill_c = !flush_c &&
                ((br_e && stall_c[2] == NO_STOP && stall_c[3] == NO_STOP) ||
                 (br_pend && stall_c[2] == NO_STOP));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_type <= 32'h0;
      pend_epc  <= 32'h0;
      br_pend   <= 1'b0;
      flush_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      flush_q <= flush_c;

      case (state)
        RUN: begin
          if (exc_take) begin
            if (stallreq_from_mem) begin
              pend_type <= excepttype_i;
              pend_epc  <= cp0_epc_i;
              state     <= EXC_WAIT;
            end else if (stallreq_from_if) begin
              state <= DRAIN;
            end
          end
        end
        EXC_WAIT: begin
          if (!stallreq_from_mem) state <= stallreq_from_if ? DRAIN : RUN;
        end
        DRAIN: begin
          if (!stallreq_from_if) state <= RUN;
        end
        default: state <= RUN;
      endcase

      // A branch arriving with an exception belongs to a younger instruction that gets flushed.
      if (flush_c)
        br_pend <= 1'b0;
      else if (br_e && stall_c[2] == STOP && !exc_take)
        br_pend <= 1'b1;
      else if (br_pend && stall_c[2] == NO_STOP)
        br_pend <= 1'b0;

      if (stall_c[0] == STOP && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end

  // Combinational outputs are held quiet while reset is asserted.
  assign stall        = rst ? stall_c   : STALL_NONE;
  assign flush        = rst & flush_c;
  assign new_pc       = rst ? new_pc_c  : 32'h0;
  assign br_kill      = rst & br_kill_c;
  assign drop_if      = rst & drop_if_c;
  assign stall_cycles = cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter width reduced so saturation is reachable.
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          stallreq_from_if;
  logic          stallreq_from_id;
  logic          stallreq_from_ex;
  logic          stallreq_from_mem;
  logic          br_e;
  logic          except_valid;
  logic [31:0]   excepttype_i;
  logic [31:0]   cp0_epc_i;
  logic [5:0]    stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          br_kill;
  logic          drop_if;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .br_e              (br_e),
    .except_valid      (except_valid),
    .excepttype_i      (excepttype_i),
    .cp0_epc_i         (cp0_epc_i),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .br_kill           (br_kill),
    .drop_if           (drop_if),
    .stall_cycles      (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stallreq_from_if  = 1'b0;
    stallreq_from_id  = 1'b0;
    stallreq_from_ex  = 1'b0;
    stallreq_from_mem = 1'b0;
    br_e              = 1'b0;
    except_valid      = 1'b0;
    excepttype_i      = 32'h0;
    cp0_epc_i         = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall got %b want 000000", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h want 0", new_pc); end
    checks++; if (br_kill !== 1'b0 || drop_if !== 1'b0) begin errors++; $display("FAIL reset_kill_drop got %b%b want 00", br_kill, drop_if); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
  endtask

  task automatic test_stall_priority();
    do_reset();
    stallreq_from_id = 1'b1; stallreq_from_if = 1'b1; #1;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL prio_id_if got %b want 000111", stall); end
    tick();
    stallreq_from_ex = 1'b1; #1;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL prio_ex got %b want 001111", stall); end
    tick();
    idle(); stallreq_from_mem = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_mem got %b want 011111", stall); end
    tick();
    idle(); stallreq_from_if = 1'b1; #1;
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL prio_if got %b want 000011", stall); end
    tick();
    idle(); #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL prio_none got %b want 000000", stall); end
    checks++; if (stall_cycles !== 4'd4) begin errors++; $display("FAIL cnt_after4 got %0d want 4", stall_cycles); end
    tick();
    checks++; if (stall_cycles !== 4'd4) begin errors++; $display("FAIL cnt_hold got %0d want 4", stall_cycles); end
  endtask

  task automatic test_saturation();
    do_reset();
    stallreq_from_if = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle(); #1;
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d want 15", stall_cycles); end
    stallreq_from_ex = 1'b1;
    tick();
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL cnt_sat_hold got %0d want 15", stall_cycles); end
    idle();
  endtask

  task automatic test_exc_immediate();
    do_reset();
    except_valid = 1'b1; excepttype_i = 32'h4; cp0_epc_i = 32'h80000010; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush got %b want 1", flush); end
    checks++; if (new_pc !== 32'hBFC00380) begin errors++; $display("FAIL exc_new_pc got %h want bfc00380", new_pc); end
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL exc_stall got %b want 000000", stall); end
    tick();
    idle(); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_next got %b want 0", flush); end
    tick();
    except_valid = 1'b1; excepttype_i = 32'hE; cp0_epc_i = 32'h80001234; stallreq_from_ex = 1'b1; #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h80001234) begin errors++; $display("FAIL eret_redirect got %b/%h want 1/80001234", flush, new_pc); end
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL eret_ex_stall got %b want 000000", stall); end
    tick();
    idle(); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL eret_flush_next got %b want 0", flush); end
    tick();
  endtask

  task automatic test_exc_deferred();
    do_reset();
    except_valid = 1'b1; stallreq_from_mem = 1'b1; excepttype_i = 32'hE; cp0_epc_i = 32'h80005678; #1;
    checks++; if (flush !== 1'b0 || stall !== 6'b011111) begin errors++; $display("FAIL defer_c1 got %b/%b want 0/011111", flush, stall); end
    tick();
    excepttype_i = 32'h4; cp0_epc_i = 32'hDEAD0000; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL defer_c2 got %b want 0", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL defer_c3 got %b want 0", flush); end
    tick();
    stallreq_from_mem = 1'b0; except_valid = 1'b0; #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h80005678) begin errors++; $display("FAIL defer_fire got %b/%h want 1/80005678", flush, new_pc); end
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL defer_fire_stall got %b want 000000", stall); end
    tick();
    idle(); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL defer_once got %b want 0", flush); end
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    except_valid = 1'b1; excepttype_i = 32'h4; stallreq_from_if = 1'b1; #1;
    checks++; if (flush !== 1'b1 || stall !== 6'b0) begin errors++; $display("FAIL drain_flush got %b/%b want 1/000000", flush, stall); end
    tick();
    except_valid = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (stall !== 6'b000011 || flush !== 1'b0 || drop_if !== 1'b0) begin errors++; $display("FAIL drain_hold%0d got %b/%b/%b want 000011/0/0", i, stall, flush, drop_if); end
      tick();
    end
    stallreq_from_if = 1'b0; #1;
    checks++; if (drop_if !== 1'b1 || stall !== 6'b000011) begin errors++; $display("FAIL drain_drop got %b/%b want 1/000011", drop_if, stall); end
    tick();
    checks++; if (drop_if !== 1'b0 || stall !== 6'b0) begin errors++; $display("FAIL drain_run got %b/%b want 0/000000", drop_if, stall); end
  endtask

  task automatic test_branch();
    do_reset();
    br_e = 1'b1; #1;
    checks++; if (br_kill !== 1'b1) begin errors++; $display("FAIL br_now got %b want 1", br_kill); end
    tick();
    br_e = 1'b1; stallreq_from_id = 1'b1; #1;
    checks++; if (br_kill !== 1'b0) begin errors++; $display("FAIL br_stalled got %b want 0", br_kill); end
    tick();
    br_e = 1'b0; #1;
    checks++; if (br_kill !== 1'b0) begin errors++; $display("FAIL br_wait got %b want 0", br_kill); end
    tick();
    stallreq_from_id = 1'b0; #1;
    checks++; if (br_kill !== 1'b1) begin errors++; $display("FAIL br_replay got %b want 1", br_kill); end
    tick();
    checks++; if (br_kill !== 1'b0) begin errors++; $display("FAIL br_once got %b want 0", br_kill); end
    tick();
  endtask

  task automatic test_branch_exception();
    do_reset();
    br_e = 1'b1; except_valid = 1'b1; excepttype_i = 32'h4; #1;
    checks++; if (br_kill !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL brx_now got %b/%b want 0/1", br_kill, flush); end
    tick();
    idle(); #1;
    checks++; if (br_kill !== 1'b0) begin errors++; $display("FAIL brx_after got %b want 0", br_kill); end
    tick();
    br_e = 1'b1; except_valid = 1'b1; stallreq_from_mem = 1'b1; #1;
    checks++; if (br_kill !== 1'b0) begin errors++; $display("FAIL brx_defer got %b want 0", br_kill); end
    tick();
    idle(); #1;
    checks++; if (br_kill !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL brx_fire got %b/%b want 0/1", br_kill, flush); end
    tick();
    checks++; if (br_kill !== 1'b0) begin errors++; $display("FAIL brx_pend got %b want 0", br_kill); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    except_valid = 1'b1; stallreq_from_mem = 1'b1; stallreq_from_if = 1'b1; cp0_epc_i = 32'h80000040;
    tick();
    tick();
    rst = 1'b0; #1;
    checks++; if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin errors++; $display("FAIL rstmid_out got %b/%b/%h want 0/0/0", stall, flush, new_pc); end
    checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", stall_cycles); end
    idle();
    tick();
    rst = 1'b1; #1;
    checks++; if (flush !== 1'b0 || stall !== 6'b0) begin errors++; $display("FAIL rstmid_run got %b/%b want 0/000000", flush, stall); end
    tick();
    checks++; if (flush !== 1'b0 || drop_if !== 1'b0) begin errors++; $display("FAIL rstmid_noflush got %b/%b want 0/0", flush, drop_if); end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_stall_priority();
    test_saturation();
    test_exc_immediate();
    test_exc_deferred();
    test_drain();
    test_branch();
    test_branch_exception();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
